// File: rtl/vram_arbiter_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and arbiter FSM encodings
// for the VRAM arbiter and its pixel-fetch pipeline.
package vram_arbiter_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int H_TOTAL        = 800;
  localparam int V_ACTIVE       = 480;
  localparam int V_TOTAL        = 521;
  localparam int WORDS_PER_LINE = 80;
  localparam int FB_WORDS       = 38400;

  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    ACK_GAP = 2'd2
  } arbState_t;

endpackage

// File: rtl/vga_pixel_fetch.sv
// Display fetch scheduler and next/current word double buffer; the display
// always reads one 8-pixel word ahead of the beam.
module vga_pixel_fetch
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [9:0]        iColumn,
  input  logic [9:0]        iRow,
  input  logic              iCapture,
  input  logic [WORD_W-1:0] iRamData,
  output logic              oFetch,
  output logic [ADDR_W-1:0] oFetchAddr,
  output logic [2:0]        oPixel
);

  logic [WORD_W-1:0] nextWord;
  logic [WORD_W-1:0] curWord;
  logic [9:0]        fetchRow;
  logic [6:0]        fetchWord;
  logic              loadCur;
  logic [4:0]        bitBase;

  // Column 792 prefetches word 0 of the following line so it is ready at column 0.
  always_comb begin
    fetchRow  = iRow;
    fetchWord = iColumn[9:3] + 7'd1;
    oFetch    = 1'b0;
    if (iColumn == 10'(H_TOTAL - 8)) begin
      fetchRow  = (iRow == 10'(V_TOTAL - 1)) ? 10'd0 : iRow + 10'd1;
      fetchWord = 7'd0;
      oFetch    = (fetchRow < 10'(V_ACTIVE));
    end else if (iColumn[2:0] == 3'd0 && iColumn < 10'(H_ACTIVE - 8) &&
                 iRow < 10'(V_ACTIVE)) begin
      oFetch = 1'b1;
    end
    oFetchAddr = ADDR_W'(fetchRow) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(fetchWord);
  end

  assign loadCur = (iColumn[2:0] == 3'd7 && iColumn < 10'(H_ACTIVE)) ||
                   (iColumn == 10'(H_TOTAL - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      nextWord <= '0;
      curWord  <= '0;
    end else begin
      if (iCapture) nextWord <= iRamData;
      if (loadCur)  curWord  <= nextWord;
    end
  end

  always_comb begin
    bitBase = 5'(iColumn[2:0]) * 5'd3;
    if (iColumn >= 10'(H_ACTIVE) || iRow >= 10'(V_ACTIVE)) oPixel = BLACK;
    else oPixel = curWord[bitBase +: 3];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, the CPU gets leftover
// cycles. Define VRAM_ARB_STATS_EN to build the CPU stall-cycle counter.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [9:0]        iColumn,
  input  logic [9:0]        iRow,
  output logic [2:0]        oPixel,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [WORD_W-1:0] iCpuData,
  output logic              oCpuAck,
  output logic [WORD_W-1:0] oCpuData,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic              oRamWe,
  output logic [WORD_W-1:0] oRamData,
  input  logic [WORD_W-1:0] iRamData,
  output logic [15:0]       oStallCount,
  output logic [1:0]        oDbgState
);

  // CPU handshake: iCpuReq is held with stable iCpuWe/iCpuAddr/iCpuData until
  // the single-cycle oCpuAck; oCpuData is meaningful only while oCpuAck is high.

  arbState_t         state;
  logic              tag;
  logic              rdOob;
  logic [ADDR_W-1:0] lastAddr;
  logic [WORD_W-1:0] lastData;
  logic              fetch;
  logic [ADDR_W-1:0] fetchAddr;
  logic              grant;
  logic              cpuOob;

  vga_pixel_fetch #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_fetch (
    .Clock     (Clock),
    .Reset     (Reset),
    .iColumn   (iColumn),
    .iRow      (iRow),
    .iCapture  (tag),
    .iRamData  (iRamData),
    .oFetch    (fetch),
    .oFetchAddr(fetchAddr),
    .oPixel    (oPixel)
  );

  assign cpuOob    = (iCpuAddr >= ADDR_W'(FB_WORDS));
  assign grant     = !Reset && state == IDLE && iCpuReq && !fetch;
  assign oDbgState = state;

  // The RAM bus holds its last address/data when nobody owns the cycle.
  always_comb begin
    oRamAddr = lastAddr;
    oRamData = lastData;
    oRamWe   = 1'b0;
    oCpuAck  = 1'b0;
    oCpuData = '0;
    if (fetch) begin
      oRamAddr = fetchAddr;
    end else if (grant) begin
      oRamAddr = iCpuAddr;
      if (iCpuWe) begin
        oRamData = iCpuData;
        oRamWe   = !cpuOob;
        oCpuAck  = 1'b1;
      end
    end
    if (!Reset && state == RD_DATA) begin
      oCpuAck  = 1'b1;
      oCpuData = rdOob ? '0 : iRamData;
    end
  end

  // tag marks the RAM word arriving this cycle as a display fetch.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      tag      <= 1'b0;
      rdOob    <= 1'b0;
      lastAddr <= '0;
      lastData <= '0;
    end else begin
      tag      <= fetch;
      lastAddr <= oRamAddr;
      lastData <= oRamData;
      case (state)
        IDLE: begin
          if (grant) begin
            rdOob <= cpuOob;
            state <= iCpuWe ? ACK_GAP : RD_DATA;
          end
        end
        RD_DATA: state <= ACK_GAP;
        ACK_GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stallCount;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stallCount <= '0;
    end else if (state == IDLE && iCpuReq && !grant && stallCount != 16'hFFFF) begin
      stallCount <= stallCount + 16'd1;
    end
  end

  assign oStallCount = stallCount;
`else
  assign oStallCount = '0;
`endif

endmodule
